// File: rtl/lp_seq_pkg.sv
// Shared types and constants for the SSR4-to-SSR6 low-pass filter phase sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lp_seq_pkg;

    typedef enum logic [1:0] {IDLE, ACQUIRE, FILL, RUN} lp_seq_state_t;

    localparam int PHASE_LEN     = 3;
    localparam int SLIP_CNT_BITS = 8;

    // Advance the 3-clock phase counter: 0,1,2,0,...
    function automatic logic [1:0] phase_next(input logic [1:0] p);
        return (p == 2'(PHASE_LEN - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/lp_ssr6_sequencer.sv
// Global 3-clock phase / clock-enable sequencer for a group of two-thirds-band LP filters.
// Latency: registered outputs, one clock after the inputs that cause them; a sync seen in ACQUIRE gives valid_o FILL_CYCLES+1 clocks later.
// Backpressure: none; run_i low returns to IDLE on the next clock and overrides sync, slip and timeout handling.
//
// Ports: clk_i/rst_n_i (sync active-low reset), run_i enable, sync_i periodic phase-group marker,
//        slip_clr_i clears the slip counter; clk_phase_o/ce_o drive the filters, locked_o/valid_o
//        qualify them, slip_o/slip_count_o report misaligned syncs, timeout_o flags sync loss.
// Optional macro LP_SSR6_SEQ_SYNC_TIMEOUT_EN builds the sync-loss watchdog; otherwise timeout_o is 0.
module lp_ssr6_sequencer
    import lp_seq_pkg::*;
#(
    parameter int FILL_CYCLES  = 16,
    parameter int SYNC_TIMEOUT = 768
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     run_i,
    input  logic                     sync_i,
    input  logic                     slip_clr_i,
    output logic                     clk_phase_o,
    output logic                     ce_o,
    output logic                     locked_o,
    output logic                     valid_o,
    output logic                     slip_o,
    output logic [SLIP_CNT_BITS-1:0] slip_count_o,
    output logic                     timeout_o
);

    localparam logic [7:0]               FILL_LAST  = 8'(FILL_CYCLES - 1);
    localparam logic [1:0]               PHASE_LAST = 2'(PHASE_LEN - 1);
    localparam logic [SLIP_CNT_BITS-1:0] SLIP_MAX   = '1;

    lp_seq_state_t            state_q, state_n;
    logic [1:0]               cnt_q, cnt_n;
    logic [7:0]               fill_q, fill_n;
    logic [SLIP_CNT_BITS-1:0] slip_cnt_n;
    logic                     slip_n;
    logic                     locked_cur, locked_n;
    logic                     slip_det;

`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
    localparam logic [15:0] TOUT_LIM = 16'(SYNC_TIMEOUT);
    logic [15:0] tcnt_q, tcnt_n;
    logic        timeout_n;
`endif

    assign locked_cur = (state_q == FILL) || (state_q == RUN);
    // Only a sync landing on the last clock of a phase group is aligned.
    assign slip_det   = run_i && sync_i && locked_cur && (cnt_q != PHASE_LAST);
    assign locked_n   = (state_n == FILL) || (state_n == RUN);

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        fill_n     = fill_q;
        slip_cnt_n = slip_count_o;
        slip_n     = 1'b0;
`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
        timeout_n  = timeout_o;
        tcnt_n     = '0;
`endif
        case (state_q)
            IDLE: begin
                cnt_n  = '0;
                fill_n = '0;
                if (run_i) state_n = ACQUIRE;
            end
            ACQUIRE: begin
                cnt_n  = '0;
                fill_n = '0;
                if (sync_i) begin
                    state_n = FILL;
`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
                    timeout_n = 1'b0;
`endif
                end
            end
            FILL: begin
                cnt_n  = phase_next(cnt_q);
                fill_n = fill_q + 8'd1;
                if (fill_q == FILL_LAST) state_n = RUN;
            end
            RUN: begin
                cnt_n = phase_next(cnt_q);
            end
            default: state_n = IDLE;
        endcase

`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
        // Any sync restarts the watchdog, so it can never coincide with a slip.
        if (state_q == RUN && !sync_i) begin
            tcnt_n = tcnt_q + 16'd1;
            if (tcnt_n == TOUT_LIM) begin
                state_n   = ACQUIRE;
                cnt_n     = '0;
                fill_n    = '0;
                timeout_n = 1'b1;
            end
        end
`endif

        // A slip realigns the phase to this sync and refills the pipeline.
        if (slip_det) begin
            state_n = FILL;
            cnt_n   = '0;
            fill_n  = '0;
            slip_n  = 1'b1;
            if (slip_cnt_n != SLIP_MAX) slip_cnt_n = slip_cnt_n + 1'b1;
        end

        if (slip_clr_i) slip_cnt_n = '0;

        if (!run_i) begin
            state_n = IDLE;
            cnt_n   = '0;
            fill_n  = '0;
`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
            timeout_n = timeout_o;
            tcnt_n    = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fill_q       <= '0;
            slip_count_o <= '0;
            slip_o       <= 1'b0;
            locked_o     <= 1'b0;
            valid_o      <= 1'b0;
            clk_phase_o  <= 1'b0;
            ce_o         <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            fill_q       <= fill_n;
            slip_count_o <= slip_cnt_n;
            slip_o       <= slip_n;
            locked_o     <= locked_n;
            valid_o      <= (state_n == RUN);
            clk_phase_o  <= locked_n && (cnt_n == PHASE_LAST);
            ce_o         <= locked_n && (cnt_n != 2'd0);
        end
    end

`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tcnt_q    <= '0;
            timeout_o <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_n;
            timeout_o <= timeout_n;
        end
    end
`else
    assign timeout_o = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^SYNC_TIMEOUT;
`endif

endmodule

// File: tb/tb_lp_ssr6_sequencer.sv
// Self-checking bench for lp_ssr6_sequencer against an anchor-based phase model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_lp_ssr6_sequencer;

    localparam int FILL = 16;
    localparam int TOUT = 96;

    logic       clk = 1'b0;
    logic       rst_n, run, sync, slip_clr;
    logic       clk_phase, ce, locked, valid, slip, timeout;
    logic [7:0] slip_count;

    always #5 clk = ~clk;

    lp_ssr6_sequencer #(.FILL_CYCLES(FILL), .SYNC_TIMEOUT(TOUT)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .run_i       (run),
        .sync_i      (sync),
        .slip_clr_i  (slip_clr),
        .clk_phase_o (clk_phase),
        .ce_o        (ce),
        .locked_o    (locked),
        .valid_o     (valid),
        .slip_o      (slip),
        .slip_count_o(slip_count),
        .timeout_o   (timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: once locked, the phase is a pure function of the clock edge at which
    // the last alignment (accepted sync or slip) took effect.
    bit m_armed, m_active, m_slip, m_tout;
    int m_anchor, m_slips, m_quiet;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit rn, input bit s, input bit c);
        bit in_run;
        int ph;
        if (!r) begin
            m_armed = 0; m_active = 0; m_slip = 0; m_slips = 0; m_tout = 0; m_quiet = 0;
            return;
        end
        m_slip = 0;
        if (!rn) begin
            m_armed = 0; m_active = 0; m_quiet = 0;
            if (c) m_slips = 0;
            return;
        end
        in_run = m_active && (cyc - 1 - m_anchor >= FILL);
        if (m_active) begin
            ph = (cyc - 1 - m_anchor) % 3;
            if (s && ph != 2) begin
                m_slip = 1;
                if (m_slips < 255) m_slips++;
                m_anchor = cyc;
            end
        end else if (m_armed) begin
            if (s) begin
                m_active = 1; m_armed = 0; m_anchor = cyc; m_tout = 0;
            end
        end else begin
            m_armed = 1;
        end
`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
        if (in_run && !s) begin
            m_quiet++;
            if (m_quiet == TOUT) begin
                m_active = 0; m_armed = 1; m_tout = 1; m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
        end
`else
        if (in_run) m_quiet = 0;
`endif
        if (c) m_slips = 0;
    endtask

    task automatic compare();
        int  ph;
        bit  v;
        ph = m_active ? (cyc - m_anchor) % 3 : 0;
        v  = m_active && (cyc - m_anchor >= FILL);
        chk("locked",     32'(locked),     32'(m_active));
        chk("valid",      32'(valid),      32'(v));
        chk("clk_phase",  32'(clk_phase),  32'(m_active && ph == 2));
        chk("ce",         32'(ce),         32'(m_active && ph != 0));
        chk("slip",       32'(slip),       32'(m_slip));
        chk("slip_count", 32'(slip_count), 32'(m_slips));
        chk("timeout",    32'(timeout),    32'(m_tout));
    endtask

    task automatic step(input bit r, input bit rn, input bit s, input bit c);
        rst_n = r; run = rn; sync = s; slip_clr = c;
        @(posedge clk);
        cyc++;
        model_step(r, rn, s, c);
        #1;
        compare();
    endtask

    initial begin
        int base, first_ph, first_v, slip_seen, back_v;
        rst_n = 1'b0; run = 1'b1; sync = 1'b0; slip_clr = 1'b0;

        // Reset held with run high.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_valid",  32'(valid),  0);
        chk("rst_count",  32'(slip_count), 0);

        // Lock-up: sync in cycle 10, period 48.
        base = cyc; first_ph = -1; first_v = -1; slip_seen = 0;
        for (int k = 0; k < 150; k++) begin
            step(1, 1, (k >= 10) && ((k - 10) % 48 == 0), 0);
            if (clk_phase && first_ph < 0) first_ph = cyc - base;
            if (valid && first_v < 0) first_v = cyc - base;
            if (slip) slip_seen++;
        end
        chk("first_clk_phase", 32'(first_ph), 13);
        chk("first_valid",     32'(first_v),  27);
        chk("no_slip",         32'(slip_seen), 0);

        // One sync shifted by +1: 154 would be aligned, 155 is a slip.
        back_v = -1;
        for (int k = 150; k < 260; k++) begin
            step(1, 1, (k == 155) || ((k > 155) && ((k - 155) % 48 == 0)), 0);
            if (k == 155) begin
                chk("shift_slip",  32'(slip), 1);
                chk("shift_count", 32'(slip_count), 1);
                chk("shift_valid", 32'(valid), 0);
            end
            if (k > 155 && valid && back_v < 0) back_v = cyc - base;
            if (k > 155 && slip) slip_seen++;
        end
        chk("valid_back", 32'(back_v), 172);
        chk("realigned_no_slip", 32'(slip_seen), 0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++)
            step(1, ($urandom % 80) != 0, ($urandom % 12) == 0, ($urandom % 50) == 0);

        // Saturation: sync held high keeps slipping every clock.
        step(1, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        for (int k = 0; k < 300; k++) step(1, 1, 1, 0);
        chk("sat_count", 32'(slip_count), 255);
        step(1, 1, 1, 1);
        chk("clr_count", 32'(slip_count), 0);
        chk("clr_slip",  32'(slip), 1);

        // run dropped in RUN together with sync.
        step(1, 1, 1, 0);
        for (int k = 0; k < 25; k++) step(1, 1, 0, 0);
        chk("pre_drop_valid", 32'(valid), 1);
        step(1, 0, 1, 0);
        chk("drop_locked",    32'(locked),    0);
        chk("drop_valid",     32'(valid),     0);
        chk("drop_clk_phase", 32'(clk_phase), 0);
        chk("drop_ce",        32'(ce),        0);

        // Reset pulse during FILL.
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
        chk("fill_locked", 32'(locked), 1);
        chk("fill_valid",  32'(valid),  0);
        step(0, 1, 0, 0);
        chk("rstfill_locked", 32'(locked), 0);
        chk("rstfill_ce",     32'(ce),     0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("reacquire_locked", 32'(locked), 1);

`ifdef LP_SSR6_SEQ_SYNC_TIMEOUT_EN
        // Syncs stop: watchdog drops back to ACQUIRE.
        for (int k = 0; k < FILL + TOUT + 10; k++) step(1, 1, 0, 0);
        chk("tout_flag",  32'(timeout), 1);
        chk("tout_valid", 32'(valid),   0);
        step(1, 1, 1, 0);
        chk("tout_clear",  32'(timeout), 0);
        chk("tout_locked", 32'(locked),  1);
        for (int k = 0; k < 20; k++) step(1, 1, 0, 0);
`else
        for (int k = 0; k < 200; k++) step(1, 1, 0, 0);
        chk("no_timeout", 32'(timeout), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
